// File: rtl/dp_fifo_arbiter.sv
// dp_fifo_arbiter: shares one dp_sync_fifo between two requesters; all writes on port A, all reads on port B.
// Latency: wr_ack/rd_ack are combinational; rd_valid/rd_data arrive RD_LAT+1 cycles after rd_ack.
// Backpressure: writes are held off while fifo_full and reads while fifo_empty; requesters keep req high until acked.
// Optional: define ARB_STATS_EN to build the per-requester stall counters (otherwise they read 0).

// Round-robin arbiter for one direction, with bounded burst ownership.
module dp_fifo_arb_fsm #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       block,
  output logic [1:0] ack
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     state, state_nxt;
  logic [7:0] bcnt, bcnt_nxt;
  logic       lp, lp_nxt;
  logic       owned, owner;
  logic       gnt_vld, gnt_id;

  assign owned = (state == OWN0) || (state == OWN1);
  assign owner = (state == OWN1);

  // Pick a grant, qualify it against block/reset, and work out the next owner and burst count.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_id    = 1'b0;
    ack       = 2'b00;
    state_nxt = state;
    bcnt_nxt  = bcnt;
    lp_nxt    = lp;

    if (owned) begin
      if (req[owner] && ((bcnt < 8'(MAX_BURST)) || !req[~owner])) begin
        gnt_vld = 1'b1;
        gnt_id  = owner;
      end else if (req[~owner]) begin
        gnt_vld = 1'b1;
        gnt_id  = ~owner;
      end
    end else begin
      if (req == 2'b11) begin
        gnt_vld = 1'b1;
        gnt_id  = ~lp;
      end else if (req != 2'b00) begin
        gnt_vld = 1'b1;
        gnt_id  = req[1];
      end
    end

    // Acks are suppressed while reset is asserted so nothing is accepted and later dropped.
    if (gnt_vld && !block && rst) begin
      ack    = gnt_id ? 2'b10 : 2'b01;
      lp_nxt = gnt_id;
      if (owned && (owner == gnt_id)) begin
        bcnt_nxt = (bcnt == 8'hFF) ? bcnt : bcnt + 8'd1;
      end else begin
        state_nxt = gnt_id ? OWN1 : OWN0;
        bcnt_nxt  = 8'd1;
      end
    end else if (req == 2'b00) begin
      state_nxt = IDLE;
    end
  end

  // State register; lp resets to 1 so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bcnt  <= 8'd0;
      lp    <= 1'b1;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      lp    <= lp_nxt;
    end
  end

endmodule

module dp_fifo_arbiter #(
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       wr_req,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic [WIDTH-1:0] wr_data1,
  output logic [1:0]       wr_ack,
  input  logic [1:0]       rd_req,
  output logic [1:0]       rd_ack,
  output logic [1:0]       rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             fifo_wra,
  output logic [WIDTH-1:0] fifo_dina,
  output logic             fifo_rdb,
  output logic             fifo_wrb,
  output logic             fifo_rda,
  output logic [WIDTH-1:0] fifo_dinb,
  input  logic [WIDTH-1:0] fifo_doutb,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic             fifo_conflict,
  output logic             conflict_err,
  output logic [CNT_W-1:0] stall_cnt0,
  output logic [CNT_W-1:0] stall_cnt1
);

  logic [RD_LAT:1] pipe_vld;
  logic [RD_LAT:1] pipe_id;

  dp_fifo_arb_fsm #(.MAX_BURST(MAX_BURST)) u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wr_req),
    .block (fifo_full),
    .ack   (wr_ack)
  );

  dp_fifo_arb_fsm #(.MAX_BURST(MAX_BURST)) u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (rd_req),
    .block (fifo_empty),
    .ack   (rd_ack)
  );

  // Writes only ever use port A and reads only port B, so the FIFO can never see a same-port clash.
  assign fifo_wra  = |wr_ack;
  assign fifo_dina = wr_ack[0] ? wr_data0 : (wr_ack[1] ? wr_data1 : '0);
  assign fifo_rdb  = |rd_ack;
  assign fifo_wrb  = 1'b0;
  assign fifo_rda  = 1'b0;
  assign fifo_dinb = '0;

  // Carry {valid, requester id} alongside the FIFO read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[1] <= fifo_rdb;
      pipe_id[1]  <= rd_ack[1];
      for (int i = 2; i <= RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  // Register the returning word and tag it; rd_data holds between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 2'b00;
      rd_data  <= '0;
    end else if (pipe_vld[RD_LAT]) begin
      rd_valid <= pipe_id[RD_LAT] ? 2'b10 : 2'b01;
      rd_data  <= fifo_doutb;
    end else begin
      rd_valid <= 2'b00;
    end
  end

  // Sticky record of any FIFO port conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_err <= 1'b0;
    end else if (fifo_conflict) begin
      conflict_err <= 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  logic [1:0] stall;

  assign stall[0] = (wr_req[0] & ~wr_ack[0]) | (rd_req[0] & ~rd_ack[0]);
  assign stall[1] = (wr_req[1] & ~wr_ack[1]) | (rd_req[1] & ~rd_ack[1]);

  // One saturating increment per cycle a requester is waiting in either direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt0 <= '0;
      stall_cnt1 <= '0;
    end else begin
      if (stall[0] && (stall_cnt0 != '1)) stall_cnt0 <= stall_cnt0 + CNT_W'(1);
      if (stall[1] && (stall_cnt1 != '1)) stall_cnt1 <= stall_cnt1 + CNT_W'(1);
    end
  end
`else
  assign stall_cnt0 = '0;
  assign stall_cnt1 = '0;
`endif

endmodule

// File: tb/tb_dp_fifo_arbiter.sv
// tb_dp_fifo_arbiter: drives dp_fifo_arbiter against a queue-based FIFO and a behavioural arbiter model.
// Latency: checks every falling edge; responses expected RD_LAT+1 cycles after a read is acked.
// Backpressure: the bench FIFO reports full/empty from its own occupancy; requesters hold req until ack.
module tb_dp_fifo_arbiter;
  localparam int WIDTH = 64, MAX_BURST = 4, RD_LAT = 1, CNT_W = 16, DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] wr_req = 2'b00, rd_req = 2'b00;
  logic [WIDTH-1:0] wr_data0 = '0, wr_data1 = '0;
  logic [1:0] wr_ack, rd_ack, rd_valid;
  logic [WIDTH-1:0] rd_data, fifo_dina, fifo_dinb;
  logic fifo_wra, fifo_rdb, fifo_wrb, fifo_rda, conflict_err;
  logic [WIDTH-1:0] fifo_doutb = '0;
  logic fifo_empty, fifo_full;
  logic fifo_conflict = 1'b0;
  logic [CNT_W-1:0] stall_cnt0, stall_cnt1;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  dp_fifo_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_wra(fifo_wra), .fifo_dina(fifo_dina), .fifo_rdb(fifo_rdb), .fifo_wrb(fifo_wrb),
    .fifo_rda(fifo_rda), .fifo_dinb(fifo_dinb), .fifo_doutb(fifo_doutb), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_conflict(fifo_conflict), .conflict_err(conflict_err),
    .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int id; logic [WIDTH-1:0] data; int due; } resp_t;
  resp_t pend[$];
  logic [WIDTH-1:0] fq[$];
  int fcount = 0;
  int own[2], streak[2], last[2];
  int cyc_n = 0;
  int exp_st[2];
  logic [1:0] exp_rv = 2'b00;
  logic [WIDTH-1:0] exp_rd = '0;
  logic exp_conf = 1'b0;
  logic [1:0] s_wreq, s_rreq, s_wack, s_rack;
  logic [WIDTH-1:0] s_wd0, s_wd1;
  logic s_conf;

  assign fifo_full  = (fcount == DEPTH);
  assign fifo_empty = (fcount == 0);

  // Who should win, given who currently owns the direction and how long they have held it.
  function automatic int pick(input int d, input logic [1:0] req);
    int o;
    o = own[d];
    if (req == 2'b00) return -1;
    if (o < 0) begin
      if (req == 2'b11) return 1 - last[d];
      return req[1] ? 1 : 0;
    end
    if (req[o] && (streak[d] < MAX_BURST || !req[1-o])) return o;
    if (req[1-o]) return 1 - o;
    return -1;
  endfunction

  task automatic arb_step(input int d, input logic [1:0] req, input logic [1:0] ack);
    int g;
    if (ack != 2'b00) begin
      g = ack[1] ? 1 : 0;
      if (g == own[d]) streak[d] = (streak[d] < 255) ? streak[d] + 1 : 255;
      else begin
        own[d] = g;
        streak[d] = 1;
      end
      last[d] = g;
    end else if (req == 2'b00) begin
      own[d] = -1;
    end
  endtask

  task automatic model_edge();
    resp_t r;
    logic [WIDTH-1:0] w;
    if (!rst) begin
      fq.delete();
      fcount <= 0;
      return;
    end
    cyc_n++;
    exp_rv = 2'b00;
    if (pend.size() > 0 && pend[0].due == cyc_n) begin
      r = pend.pop_front();
      exp_rv = (r.id == 1) ? 2'b10 : 2'b01;
      exp_rd = r.data;
    end
    if (s_rack != 2'b00) begin
      w = fq.pop_front();
      r.id = s_rack[1] ? 1 : 0;
      r.data = w;
      r.due = cyc_n + RD_LAT;
      pend.push_back(r);
      fifo_doutb <= w;
    end
    if (s_wack != 2'b00) fq.push_back(s_wack[0] ? s_wd0 : s_wd1);
    fcount <= fq.size();
    arb_step(0, s_wreq, s_wack);
    arb_step(1, s_rreq, s_rack);
`ifdef ARB_STATS_EN
    for (int k = 0; k < 2; k++)
      if (((s_wreq[k] && !s_wack[k]) || (s_rreq[k] && !s_rack[k])) && exp_st[k] < (1 << CNT_W) - 1)
        exp_st[k]++;
`endif
    if (s_conf) exp_conf = 1'b1;
  endtask

  task automatic model_check();
    logic [1:0] ew, er;
    logic [WIDTH-1:0] edin;
    int g;
    ew = 2'b00;
    er = 2'b00;
    if (!rst) begin
      own = '{-1, -1};
      streak = '{0, 0};
      last = '{1, 1};
      exp_st = '{0, 0};
      pend.delete();
      exp_rv = 2'b00;
      exp_rd = '0;
      exp_conf = 1'b0;
    end else begin
      g = pick(0, wr_req);
      if (g >= 0 && !fifo_full) ew = (g == 1) ? 2'b10 : 2'b01;
      g = pick(1, rd_req);
      if (g >= 0 && !fifo_empty) er = (g == 1) ? 2'b10 : 2'b01;
    end
    edin = ew[0] ? wr_data0 : (ew[1] ? wr_data1 : '0);
    chk("wr_ack", 64'(wr_ack), 64'(ew));
    chk("rd_ack", 64'(rd_ack), 64'(er));
    chk("fifo_wra", 64'(fifo_wra), 64'(|ew));
    chk("fifo_dina", fifo_dina, edin);
    chk("fifo_rdb", 64'(fifo_rdb), 64'(|er));
    chk("tie_offs", {62'd0, fifo_wrb, fifo_rda} | fifo_dinb, 64'd0);
    chk("wra_on_full", 64'(fifo_wra & fifo_full), 64'd0);
    chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
    chk("rd_data", rd_data, exp_rd);
    chk("conflict_err", 64'(conflict_err), 64'(exp_conf));
    chk("stall_cnt0", 64'(stall_cnt0), 64'(exp_st[0]));
    chk("stall_cnt1", 64'(stall_cnt1), 64'(exp_st[1]));
    s_wreq = wr_req; s_rreq = rd_req; s_wack = ew; s_rack = er;
    s_wd0 = wr_data0; s_wd1 = wr_data1; s_conf = fifo_conflict;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_check();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wr_req = 2'b00;
    rd_req = 2'b00;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int exp_order[12];
    int got[$];
    int exp_stall;
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_conflict", 64'(conflict_err), 64'd0);
    step();
    step();
    rst = 1'b1;

    // single write then single read, response two cycles after the read ack
    wr_req = 2'b01; wr_data0 = 64'hA5;
    @(negedge clk);
    chk("t1_wr_ack", 64'(wr_ack), 64'h1);
    chk("t1_fifo_wra", 64'(fifo_wra), 64'h1);
    chk("t1_fifo_dina", fifo_dina, 64'hA5);
    step();
    wr_req = 2'b00; rd_req = 2'b10;
    @(negedge clk);
    chk("t1_rd_ack", 64'(rd_ack), 64'h2);
    step();
    rd_req = 2'b00;
    @(negedge clk);
    chk("t1_rd_valid_early", 64'(rd_valid), 64'h0);
    step();
    @(negedge clk);
    chk("t1_rd_valid", 64'(rd_valid), 64'h2);
    chk("t1_rd_data", rd_data, 64'hA5);
    step();

    // bounded bursts with both requesters writing
    do_reset();
    wr_req = 2'b11; wr_data0 = 64'h11; wr_data1 = 64'h22;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("burst_order", 64'(wr_ack), (exp_order[i] == 1) ? 64'h2 : 64'h1);
      step();
    end
    wr_req = 2'b00;

    // top up to full, then a write and a read together
    wr_req = 2'b01; wr_data0 = 64'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step();
    end
    rd_req = 2'b10;
    @(negedge clk);
    chk("full_wr_blocked", 64'(wr_ack), 64'h0);
    chk("full_rd_ack", 64'(rd_ack), 64'h2);
    step();
    rd_req = 2'b00;
    @(negedge clk);
    chk("full_wr_retry", 64'(wr_ack), 64'h1);
    step();
    wr_req = 2'b00;

    // drain with both requesters reading
    rd_req = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      step();
    end
    rd_req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step();
    end

    // reads on empty are never acked
    rd_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty_rd_ack", 64'(rd_ack), 64'h0);
      chk("empty_rd_valid", 64'(rd_valid), 64'h0);
      step();
    end
    wr_req = 2'b10; wr_data1 = 64'h31;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_ack != 2'b00) got.push_back(rd_ack[1] ? 1 : 0);
      step();
      if (i == 0) wr_data1 = 64'h32;
      else if (i == 1) wr_data1 = 64'h33;
      else wr_req = 2'b00;
    end
    rd_req = 2'b00;
    chk("refill_read_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < got.size(); i++) chk("refill_read_id", 64'(got[i]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step();
    end

    // reset with a read in flight
    wr_req = 2'b01; wr_data0 = 64'h77;
    step();
    wr_req = 2'b00; rd_req = 2'b01;
    @(negedge clk);
    chk("rst_rd_ack_before", 64'(rd_ack), 64'h1);
    step();
    rst = 1'b0; wr_req = 2'b01; rd_req = 2'b11;
    @(negedge clk);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
    chk("rst_wr_ack", 64'(wr_ack), 64'h0);
    chk("rst_rd_ack", 64'(rd_ack), 64'h0);
    step();
    step();
    rst = 1'b1; wr_req = 2'b00; rd_req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(rd_valid), 64'h0);
      step();
    end

    // sticky conflict flag
    fifo_conflict = 1'b1;
    step();
    fifo_conflict = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("conflict_sticky", 64'(conflict_err), 64'h1);
      step();
    end

    // stall counting while the FIFO is full
    do_reset();
    @(negedge clk);
    chk("conflict_cleared", 64'(conflict_err), 64'h0);
    wr_req = 2'b01;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data0 = 64'(i + 100);
      @(negedge clk);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      step();
    end
    wr_req = 2'b00;
    @(negedge clk);
`ifdef ARB_STATS_EN
    exp_stall = 5;
`else
    exp_stall = 0;
`endif
    chk("stall_cnt0_full", 64'(stall_cnt0), 64'(exp_stall));
    chk("stall_cnt1_idle", 64'(stall_cnt1), 64'd0);
    step();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
